legv8_fetch_unit: RTL and testbench
===================================

Name: legv8_fetch_unit

Overview:
Instruction-fetch stage of the multi-cycle LEGv8 core, directly upstream of the FSM control unit.
- Holds the PC and issues requests to instruction memory with a valid handshake.
- Latches the returned 32-bit word into the instruction register and presents it zero-extended as the 64-bit INSTRUCTION bus the control FSM decodes.
- Advances the PC sequentially, or to a branch target, when the FSM acknowledges the instruction.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
TIMEOUT_CYCLES, 16, maximum cycles in S_WAIT before a fetch fault; range 1..255.

Ports:
CLOCK  input  1  single clock; all state changes on rising edge.
RESET  input  1  asynchronous, active-high reset.
FETCH_EN  input  1  FSM request to fetch the next instruction; sampled in S_IDLE only.
INSTR_ACK  input  1  FSM has consumed INSTRUCTION; sampled in S_HOLD only.
BRANCH_TAKEN  input  1  take BRANCH_TARGET as next PC; sampled with INSTR_ACK.
BRANCH_TARGET  input  64  next-PC value when BRANCH_TAKEN.
IMEM_ADDR  output  64  instruction memory address; always equals PC.
IMEM_REQ  output  1  registered memory request.
IMEM_RDATA  input  32  instruction word from memory.
IMEM_VALID  input  1  IMEM_RDATA valid this cycle.
INSTRUCTION  output  64  {32'b0, IR}.
INSTR_VALID  output  1  INSTRUCTION holds a new, unconsumed instruction.
PC  output  64  address of the instruction in IR / being fetched.
FETCH_FAULT  output  1  sticky fault flag: timeout or misaligned target.

Behaviour:
Reset values (asynchronous, RESET high):
- PC = RESET_PC; IR = 0; IMEM_REQ = 0; INSTR_VALID = 0; FETCH_FAULT = 0; timeout counter = 0; state = S_IDLE.

State machine; all outputs registered unless stated.
- S_IDLE: IMEM_REQ = 0, INSTR_VALID = 0.
  - FETCH_EN = 1 and FETCH_FAULT = 0 -> S_WAIT, IMEM_REQ = 1 from the next cycle, counter cleared.
  - FETCH_EN is ignored while FETCH_FAULT = 1.
- S_WAIT: IMEM_REQ held at 1; counter increments each cycle.
  - IMEM_VALID = 1 -> IR <= IMEM_RDATA, IMEM_REQ <= 0, INSTR_VALID <= 1, go to S_HOLD.
  - Counter reaches TIMEOUT_CYCLES with no IMEM_VALID -> FETCH_FAULT <= 1, IMEM_REQ <= 0, go to S_IDLE; IR and PC unchanged.
  - IMEM_VALID in the same cycle as the timeout: data wins, no fault.
- S_HOLD: INSTR_VALID = 1; IR and PC are stable.
  - INSTR_ACK = 1 -> INSTR_VALID <= 0, go to S_IDLE.
  - Same edge, PC update:
    - BRANCH_TAKEN = 0: PC <= PC + 4, mod 2^64, wraps silently at the top of the address space.
    - BRANCH_TAKEN = 1 and BRANCH_TARGET[1:0] = 0: PC <= BRANCH_TARGET.
    - BRANCH_TAKEN = 1 and BRANCH_TARGET[1:0] != 0: FETCH_FAULT <= 1, PC unchanged.
- IMEM_VALID outside S_WAIT is ignored.
- Latency:
  - FETCH_EN high at edge N -> IMEM_REQ high after edge N.
  - IMEM_VALID high at edge M -> INSTR_VALID/INSTRUCTION updated after edge M.
  - Minimum fetch: 2 cycles from FETCH_EN to INSTR_VALID.
  - Back-to-back fetches: INSTR_ACK -> S_IDLE for 1 cycle; FETCH_EN is re-sampled there.
- Reset mid-operation: immediate return to reset values; a late IMEM_VALID after reset deassertion lands in S_IDLE and is ignored.
- FETCH_FAULT is cleared only by RESET.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
Defined:
- Adds outputs FETCH_COUNT[31:0] and STALL_COUNT[31:0], both reset to 0.
- FETCH_COUNT increments on each IMEM_VALID capture in S_WAIT.
- STALL_COUNT increments on each S_WAIT cycle without IMEM_VALID.
- Both saturate at 32'hFFFFFFFF.
Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset with RESET_PC = 64'h400, FETCH_EN pulse, IMEM_VALID same cycle as IMEM_REQ with RDATA = 32'h8B020020 -> IMEM_ADDR = 64'h400, INSTRUCTION = 64'h000000008B020020, INSTR_VALID 2 cycles after FETCH_EN; INSTR_ACK with BRANCH_TAKEN = 0 -> PC = 64'h404.
- IMEM_VALID delayed 5 cycles -> IMEM_REQ high exactly 6 cycles, INSTR_VALID stays 0 until capture, no fault; with FETCH_PERF_CNT_EN, STALL_COUNT = 5 and FETCH_COUNT = 1.
- INSTR_ACK with BRANCH_TAKEN = 1, BRANCH_TARGET = 64'h1000 -> PC = 64'h1000, next fetch drives IMEM_ADDR = 64'h1000; BRANCH_TARGET = 64'h1002 -> FETCH_FAULT = 1, PC unchanged, later FETCH_EN ignored.
- No IMEM_VALID with TIMEOUT_CYCLES = 16 -> FETCH_FAULT rises after 16 S_WAIT cycles, IMEM_REQ drops, IR keeps its previous value.
- PC = 64'hFFFFFFFFFFFFFFFC, sequential ack -> PC = 64'h0.
- RESET asserted mid-S_WAIT, IMEM_VALID pulsed 1 cycle after release -> IMEM_REQ = 0, INSTR_VALID stays 0, IR = 0, PC = RESET_PC.

Source files
------------

// File: rtl/legv8_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : legv8_fetch_unit
// Description : LEGv8 multi-cycle instruction fetch stage (PC, IR, IMEM
//               handshake, timeout/misalignment fault). Optional performance
//               counters are enabled by defining FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module legv8_fetch_unit #(
   parameter logic [63:0] RESET_PC       = 64'h0,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        FETCH_EN,
   input  logic        INSTR_ACK,
   input  logic        BRANCH_TAKEN,
   input  logic [63:0] BRANCH_TARGET,
   output logic [63:0] IMEM_ADDR,
   output logic        IMEM_REQ,
   input  logic [31:0] IMEM_RDATA,
   input  logic        IMEM_VALID,
   output logic [63:0] INSTRUCTION,
   output logic        INSTR_VALID,
   output logic [63:0] PC,
   output logic        FETCH_FAULT
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] FETCH_COUNT,
   output logic [31:0] STALL_COUNT
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   // The counter holds the number of completed S_WAIT cycles, so the last
   // permitted cycle is seen when it equals TIMEOUT_CYCLES-1.
   localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYCLES - 1);

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [63:0] r_pc;
   logic [31:0] r_ir;
   logic        r_imem_req;
   logic        r_instr_valid;
   logic        r_fault;
   logic [7:0]  r_cnt;

   logic        w_timeout;
   logic        w_capture;
   logic        w_timeout_fault;
   logic        w_ack;
   logic        w_misaligned;
   logic        w_imem_req_nxt;
   logic        w_instr_valid_nxt;
   logic        w_fault_nxt;
   logic [63:0] w_pc_nxt;
   logic [7:0]  w_cnt_nxt;

   assign w_timeout = (r_cnt == c_cnt_last);

   // State register and registered outputs
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_ir          <= 32'h0;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
         r_fault       <= 1'b0;
         r_cnt         <= 8'h0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_imem_req    <= w_imem_req_nxt;
         r_instr_valid <= w_instr_valid_nxt;
         r_fault       <= w_fault_nxt;
         r_cnt         <= w_cnt_nxt;
         if (w_capture) begin
            r_ir <= IMEM_RDATA;
         end
      end
   end

   // Next-state logic; data arriving on the timeout cycle takes priority
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (FETCH_EN && !r_fault) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (IMEM_VALID) begin
               w_state_nxt = S_HOLD;
            end else if (w_timeout) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_HOLD: begin
            if (INSTR_ACK) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      w_capture         = (r_state == S_WAIT) && IMEM_VALID;
      w_timeout_fault   = (r_state == S_WAIT) && !IMEM_VALID && w_timeout;
      w_ack             = (r_state == S_HOLD) && INSTR_ACK;
      w_misaligned      = w_ack && BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
      w_imem_req_nxt    = (w_state_nxt == S_WAIT);
      w_instr_valid_nxt = (w_state_nxt == S_HOLD);
      w_fault_nxt       = r_fault | w_timeout_fault | w_misaligned;
      w_cnt_nxt         = (r_state == S_WAIT) ? r_cnt + 8'd1 : 8'd0;
      w_pc_nxt          = r_pc;
      if (w_ack) begin
         if (!BRANCH_TAKEN) begin
            w_pc_nxt = r_pc + 64'd4;
         end else if (!w_misaligned) begin
            w_pc_nxt = BRANCH_TARGET;
         end
      end
   end

   assign IMEM_ADDR   = r_pc;
   assign PC          = r_pc;
   assign IMEM_REQ    = r_imem_req;
   assign INSTR_VALID = r_instr_valid;
   assign INSTRUCTION = {32'h0, r_ir};
   assign FETCH_FAULT = r_fault;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_count;
   logic [31:0] r_stall_count;

   // Saturating counters
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_fetch_count <= 32'h0;
         r_stall_count <= 32'h0;
      end else if (r_state == S_WAIT) begin
         if (IMEM_VALID) begin
            if (r_fetch_count != 32'hFFFF_FFFF) begin
               r_fetch_count <= r_fetch_count + 32'd1;
            end
         end else if (r_stall_count != 32'hFFFF_FFFF) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end

   assign FETCH_COUNT = r_fetch_count;
   assign STALL_COUNT = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_legv8_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_legv8_fetch_unit
// Description : Randomized transaction-level bench for legv8_fetch_unit with
//               a behavioural PC/IR/fault model (FETCH_PERF_CNT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_legv8_fetch_unit;

   localparam logic [63:0] c_reset_pc = 64'h400;
   localparam int          c_timeout  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en, instr_ack, branch_taken, imem_valid;
   logic [63:0] branch_target;
   logic [31:0] imem_rdata;
   logic [63:0] imem_addr, instruction, pc;
   logic        imem_req, instr_valid, fetch_fault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, stall_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model of architecturally visible state
   logic [63:0] m_pc;
   logic [31:0] m_ir;
   logic        m_fault;
   longint      m_fetches, m_stalls;

   legv8_fetch_unit #(.RESET_PC(c_reset_pc), .TIMEOUT_CYCLES(c_timeout)) u_dut (
      .CLOCK        (clk),
      .RESET        (rst),
      .FETCH_EN     (fetch_en),
      .INSTR_ACK    (instr_ack),
      .BRANCH_TAKEN (branch_taken),
      .BRANCH_TARGET(branch_target),
      .IMEM_ADDR    (imem_addr),
      .IMEM_REQ     (imem_req),
      .IMEM_RDATA   (imem_rdata),
      .IMEM_VALID   (imem_valid),
      .INSTRUCTION  (instruction),
      .INSTR_VALID  (instr_valid),
      .PC           (pc),
      .FETCH_FAULT  (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
      ,
      .FETCH_COUNT  (fetch_count),
      .STALL_COUNT  (stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", {32'h0, fetch_count}, 64'(m_fetches));
      check("stall_count", {32'h0, stall_count}, 64'(m_stalls));
`endif
   endtask

   task automatic model_reset();
      m_pc = c_reset_pc; m_ir = 32'h0; m_fault = 1'b0;
      m_fetches = 0; m_stalls = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_req",   {63'h0, imem_req},    64'h0);
      check("rst_valid", {63'h0, instr_valid}, 64'h0);
      check("rst_instr", instruction,          64'h0);
      check("rst_pc",    pc,                   c_reset_pc);
      check("rst_fault", {63'h0, fetch_fault}, 64'h0);
      check_perf();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One fetch: IMEM_VALID arrives dly cycles after IMEM_REQ rises
   task automatic fetch(input int dly, input logic [31:0] data);
      int  req_cnt;
      bit  early;
      bit  timed_out;
      @(negedge clk);
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      if (m_fault) begin
         check("fault_ignore_req", {63'h0, imem_req}, 64'h0);
         check("fault_ignore_pc",  pc,                m_pc);
         return;
      end
      check("imem_addr", imem_addr, m_pc);
      req_cnt = 0;
      early   = 1'b0;
      for (int c = 0; c < c_timeout + 4; c++) begin
         if (!imem_req) break;
         req_cnt++;
         if (instr_valid) early = 1'b1;
         imem_valid = (c == dly);
         imem_rdata = (c == dly) ? data : $urandom;
         @(negedge clk);
         imem_valid = 1'b0;
      end
      timed_out = (dly >= c_timeout);
      check("req_cycles", 64'(req_cnt), timed_out ? 64'(c_timeout) : 64'(dly + 1));
      check("no_early_valid", {63'h0, early}, 64'h0);
      if (timed_out) begin
         m_fault  = 1'b1;
         m_stalls += c_timeout;
         check("to_fault", {63'h0, fetch_fault}, 64'h1);
         check("to_valid", {63'h0, instr_valid}, 64'h0);
         check("to_ir",    instruction,          {32'h0, m_ir});
         check("to_pc",    pc,                   m_pc);
      end else begin
         m_ir = data;
         m_fetches++;
         m_stalls += dly;
         check("cap_valid", {63'h0, instr_valid}, 64'h1);
         check("cap_instr", instruction,          {32'h0, m_ir});
         check("cap_fault", {63'h0, fetch_fault}, 64'h0);
      end
      check_perf();
   endtask

   // Hold for a few cycles with stray IMEM_VALID, then acknowledge
   task automatic ack(input bit taken, input logic [63:0] tgt);
      int hold;
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
         imem_valid = 1'b1;
         imem_rdata = $urandom;
         @(negedge clk);
         imem_valid = 1'b0;
         check("hold_instr", instruction, {32'h0, m_ir});
         check("hold_valid", {63'h0, instr_valid}, 64'h1);
      end
      instr_ack     = 1'b1;
      branch_taken  = taken;
      branch_target = tgt;
      @(negedge clk);
      instr_ack    = 1'b0;
      branch_taken = 1'b0;
      if (!taken)               m_pc = m_pc + 64'd4;
      else if (tgt[1:0] == 2'b00) m_pc = tgt;
      else                      m_fault = 1'b1;
      check("ack_pc",    pc,                   m_pc);
      check("ack_valid", {63'h0, instr_valid}, 64'h0);
      check("ack_fault", {63'h0, fetch_fault}, {63'h0, m_fault});
   endtask

   initial begin
      rst = 1'b1; fetch_en = 0; instr_ack = 0; branch_taken = 0;
      branch_target = 64'h0; imem_valid = 0; imem_rdata = 32'h0;
      model_reset();
      do_reset();

      // Zero-latency fetch, then sequential ack
      fetch(0, 32'h8B02_0020);
      check("first_instr", instruction, 64'h0000_0000_8B02_0020);
      ack(1'b0, 64'h0);
      check("seq_pc", pc, 64'h404);

      // Delayed response, aligned branch, then fetch from the target
      fetch(5, 32'hF840_0041);
      ack(1'b1, 64'h1000);
      fetch(0, 32'h1234_5678);
      ack(1'b0, 64'h0);

      // Data on the final permitted cycle wins over the timeout
      fetch(c_timeout - 1, 32'hAAAA_5555);

      // Wrap at the top of the address space
      ack(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      fetch(1, 32'hCAFE_F00D);
      ack(1'b0, 64'h0);
      check("wrap_pc", pc, 64'h0);

      // Misaligned branch faults; later fetches are ignored
      fetch(2, 32'h0BAD_0BAD);
      ack(1'b1, 64'h1002);
      fetch(0, 32'h1111_1111);

      // Timeout keeps IR from the previous capture
      do_reset();
      fetch(0, 32'h7777_0001);
      ack(1'b0, 64'h0);
      fetch(c_timeout + 3, 32'h0);
      fetch(0, 32'h2222_2222);

      // Reset during S_WAIT with a late IMEM_VALID after release
      do_reset();
      @(negedge clk);
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_req", {63'h0, imem_req}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      imem_valid = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_valid = 1'b0;
      check("late_req",   {63'h0, imem_req},    64'h0);
      check("late_valid", {63'h0, instr_valid}, 64'h0);
      check("late_ir",    instruction,          64'h0);
      check("late_pc",    pc,                   c_reset_pc);
      check_perf();

      // Randomized transactions
      for (int t = 0; t < 60; t++) begin
         int          kind;
         logic [63:0] tgt;
         if (m_fault) do_reset();
         fetch($urandom_range(0, 18), $urandom);
         if (m_fault) continue;
         kind = $urandom_range(0, 19);
         tgt  = {$urandom, $urandom};
         if (kind < 10)       ack(1'b0, tgt);
         else if (kind < 17)  ack(1'b1, {tgt[63:2], 2'b00});
         else                 ack(1'b1, {tgt[63:2], 2'(kind[1:0] == 2'b00 ? 2'b01 : kind[1:0])});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
